axis_frame_packer: RTL and testbench

Byte-to-word stream packer placed directly upstream of the DRAM-backed stream FIFO's S_AXIS input. It accepts an 8-bit AXI-Stream of framed records (e.g. captured packet bytes) and packs them little-endian into C_WIDTH-bit words. A partial final word is zero-padded, and tlast is asserted on the last word of every frame. An optional trailer word carries the frame's byte count, so the downstream reader can strip the padding.

---
 rtl/axis_frame_packer_pkg.sv | 31 +++
 rtl/axis_frame_packer.sv | 141 ++++++++++++++
 tb/tb_axis_frame_packer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_packer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_packer_pkg
//  Description : Shared types and helpers for the byte-to-word frame packer:
//                FSM state encoding and the zero-padding lane mask function.
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_frame_packer_pkg;

    // Largest number of byte lanes the lane mask helper can describe.
    localparam int unsigned c_MAX_LANES = 128;

    // Packer FSM: S_TRAILER exists only when the byte-count trailer is built in.
    typedef enum logic [0:0] {
        S_PACK    = 1'b0,
        S_TRAILER = 1'b1
    } state_t;

    // Lane k is kept when k <= idx (and k is a real lane); all higher lanes are padding.
    function automatic logic [c_MAX_LANES-1:0] lane_mask(input int unsigned idx,
                                                         input int unsigned n);
        logic [c_MAX_LANES-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < c_MAX_LANES; k++) begin
            m[k] = (k <= idx) && (k < n);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_frame_packer
//  Description : Packs an 8-bit framed AXI-Stream little-endian into C_WIDTH-bit
//                words. The final partial word of a frame is zero-padded and
//                carries tlast. Build with AXIS_FRAME_PACKER_TRAILER_EN defined
//                to append a trailer word holding the frame's byte count.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_frame_packer
    import axis_frame_packer_pkg::*;
#(
    parameter int C_WIDTH       = 64,
    parameter int C_COUNT_WIDTH = 16
) (
    input  logic               clk_axis,
    input  logic               rst_axis,
    input  logic [7:0]         s_axis_tdata,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    output logic [C_WIDTH-1:0] m_axis_tdata,
    output logic               m_axis_tlast,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [31:0]        frame_count
);

    localparam int unsigned c_N_LANES = C_WIDTH / 8;
    localparam int unsigned c_IDX_W   = $clog2(c_N_LANES);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_N_LANES - 1);

    // Elaboration-time guard against unsupported parameter combinations.
    if ((C_WIDTH % 8) != 0 || C_WIDTH < 16 || c_N_LANES > c_MAX_LANES ||
        C_COUNT_WIDTH < 1 || C_COUNT_WIDTH > C_WIDTH) begin : g_param_check
        $error("axis_frame_packer: unsupported C_WIDTH/C_COUNT_WIDTH combination");
    end

    state_t               r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [C_WIDTH-1:0]   r_acc;
    logic [C_WIDTH-1:0]   r_m_data;
    logic                 r_m_last;
    logic                 r_m_valid;
    logic [31:0]          r_frame_count;
`ifdef AXIS_FRAME_PACKER_TRAILER_EN
    logic [C_COUNT_WIDTH-1:0] r_byte_count;
`endif

    logic                   w_out_free;
    logic                   w_accept;
    logic                   w_word_end;
    logic [C_WIDTH-1:0]     w_merged;
    // Only the low c_N_LANES bits are meaningful; the rest are deliberately ignored.
    logic [c_MAX_LANES-1:0] w_mask_full_unused;
    logic [c_N_LANES-1:0]   w_mask;

    // The output register can take a new word when empty or draining this cycle.
    assign w_out_free    = !r_m_valid || m_axis_tready;
    // Reset forces ready low combinationally so nothing is accepted during reset.
    assign s_axis_tready = !rst_axis && (r_state == S_PACK) && w_out_free;
    assign w_accept      = s_axis_tvalid && s_axis_tready;
    assign w_word_end    = w_accept && ((r_idx == c_LAST_IDX) || s_axis_tlast);

    assign w_mask_full_unused = lane_mask({{(32-c_IDX_W){1'b0}}, r_idx}, c_N_LANES);
    assign w_mask             = w_mask_full_unused[c_N_LANES-1:0];

    // Completed word: accumulator with the incoming byte in lane idx, padding above it.
    for (genvar k = 0; k < c_N_LANES; k++) begin : g_lane
        assign w_merged[8*k +: 8] = !w_mask[k]                  ? 8'h00        :
                                    (r_idx == c_IDX_W'(k))      ? s_axis_tdata :
                                                                  r_acc[8*k +: 8];
    end

    assign m_axis_tdata  = r_m_data;
    assign m_axis_tlast  = r_m_last;
    assign m_axis_tvalid = r_m_valid;
    assign frame_count   = r_frame_count;

    // Packer FSM, lane accumulator, output register and frame counter.
    always_ff @(posedge clk_axis) begin
        if (rst_axis) begin
            r_state       <= S_PACK;
            r_idx         <= '0;
            r_acc         <= '0;
            r_m_data      <= '0;
            r_m_last      <= 1'b0;
            r_m_valid     <= 1'b0;
            r_frame_count <= '0;
`ifdef AXIS_FRAME_PACKER_TRAILER_EN
            r_byte_count  <= '0;
`endif
        end else begin
            // Drain first; a word loaded below in the same cycle overrides this.
            if (r_m_valid && m_axis_tready) begin
                r_m_valid <= 1'b0;
                if (r_m_last) begin
                    r_frame_count <= r_frame_count + 32'd1;
                end
            end

            if (w_accept) begin
                if (w_word_end) begin
                    r_m_data  <= w_merged;
                    r_m_valid <= 1'b1;
`ifdef AXIS_FRAME_PACKER_TRAILER_EN
                    r_m_last  <= 1'b0;
                    if (s_axis_tlast) begin
                        r_state <= S_TRAILER;
                    end
`else
                    r_m_last  <= s_axis_tlast;
`endif
                    r_idx     <= '0;
                    r_acc     <= '0;
                end else begin
                    r_acc[8*r_idx +: 8] <= s_axis_tdata;
                    r_idx               <= r_idx + c_IDX_W'(1);
                end
            end

`ifdef AXIS_FRAME_PACKER_TRAILER_EN
            // Saturating count of accepted bytes in the current frame.
            if (w_accept && (r_byte_count != {C_COUNT_WIDTH{1'b1}})) begin
                r_byte_count <= r_byte_count + C_COUNT_WIDTH'(1);
            end

            // Trailer word goes out as soon as the output register frees up.
            if (r_state == S_TRAILER && w_out_free) begin
                r_m_data     <= C_WIDTH'(r_byte_count);
                r_m_last     <= 1'b1;
                r_m_valid    <= 1'b1;
                r_byte_count <= '0;
                r_state      <= S_PACK;
            end
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_frame_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_frame_packer
//  Description : Directed self-checking bench for axis_frame_packer (C_WIDTH=64).
//                Expectations adapt to AXIS_FRAME_PACKER_TRAILER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_frame_packer;

`ifdef AXIS_FRAME_PACKER_TRAILER_EN
    localparam bit TRL = 1'b1;
`else
    localparam bit TRL = 1'b0;
`endif

    logic        clk_axis = 1'b0;
    logic        rst_axis = 1'b1;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] frame_count;

    int checks = 0;
    int errors = 0;
    int exp_frames = 0;

    logic [63:0] got_d[$];
    logic        got_l[$];
    logic [63:0] exp_d[$];
    logic        exp_l[$];
    logic [7:0]  frm[$];
    logic        frm_last[$];

    axis_frame_packer #(.C_WIDTH(64), .C_COUNT_WIDTH(16)) dut (
        .clk_axis      (clk_axis),
        .rst_axis      (rst_axis),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_count   (frame_count)
    );

    always #5 clk_axis = ~clk_axis;

    // Inputs change at posedge+1, so the negedge view equals what the next posedge samples.
    always @(negedge clk_axis) begin
        if (!rst_axis && m_axis_tvalid && m_axis_tready) begin
            got_d.push_back(m_axis_tdata);
            got_l.push_back(m_axis_tlast);
        end
    end

    // Offer one byte (called at posedge+1), return at posedge+1 after acceptance.
    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge clk_axis);
            ok = s_axis_tready;
            @(posedge clk_axis);
            #1;
            n++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h not accepted after %0d cycles, required acceptance", d, n);
        end
    endtask

    // Wait (bounded) for n captured words, then settle a couple of cycles.
    task automatic wait_words(input int n);
        int c;
        c = 0;
        while (got_d.size() < n && c < 500) begin
            @(posedge clk_axis);
            c++;
        end
        repeat (3) @(posedge clk_axis);
        #1;
    endtask

    task automatic send_frames();
        for (int i = 0; i < frm.size(); i++) send_byte(frm[i], frm_last[i]);
    endtask

    // Reference packer: little-endian 8 lanes, zero pad, optional count trailer.
    task automatic model_frames();
        logic [63:0] w;
        int lane;
        int cnt;
        w = '0;
        lane = 0;
        cnt = 0;
        for (int i = 0; i < frm.size(); i++) begin
            w[8*lane +: 8] = frm[i];
            cnt++;
            if (lane == 7 || frm_last[i]) begin
                exp_d.push_back(w);
                exp_l.push_back(frm_last[i] && !TRL);
                if (frm_last[i] && TRL) begin
                    exp_d.push_back(64'(cnt > 65535 ? 65535 : cnt));
                    exp_l.push_back(1'b1);
                end
                if (frm_last[i]) cnt = 0;
                w = '0;
                lane = 0;
            end else begin
                lane++;
            end
        end
    endtask

    task automatic test_reset();
        rst_axis = 1'b1;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk_axis);
        @(negedge clk_axis);
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready: got %b required 0", s_axis_tready); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b required 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b required 0", m_axis_tlast); end
        checks++; if (m_axis_tdata !== 64'h0) begin errors++; $display("FAIL rst_tdata: got %h required 0", m_axis_tdata); end
        checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL rst_frame_count: got %0d required 0", frame_count); end
        @(posedge clk_axis);
        #1;
        rst_axis = 1'b0;
        @(negedge clk_axis);
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rst_release_tready: got %b required 1", s_axis_tready); end
        @(posedge clk_axis);
        #1;
    endtask

    task automatic test_full_word();
        got_d.delete(); got_l.delete();
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), i == 8);
        @(negedge clk_axis);
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b required 1", m_axis_tvalid); end
        @(posedge clk_axis); #1;
        wait_words(TRL ? 2 : 1);
        exp_frames++;
        checks++; if (got_d.size() !== (TRL ? 2 : 1)) begin errors++; $display("FAIL full_word_count: got %0d required %0d", got_d.size(), TRL ? 2 : 1); end
        if (got_d.size() >= 1) begin
            checks++; if (got_d[0] !== 64'h0807060504030201) begin errors++; $display("FAIL full_word_data: got %h required 0807060504030201", got_d[0]); end
            checks++; if (got_l[0] !== !TRL) begin errors++; $display("FAIL full_word_last: got %b required %b", got_l[0], !TRL); end
        end
        if (TRL && got_d.size() >= 2) begin
            checks++; if (got_d[1] !== 64'd8 || got_l[1] !== 1'b1) begin errors++; $display("FAIL full_word_trailer: got %h/%b required 8/1", got_d[1], got_l[1]); end
        end
        checks++; if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL full_word_frames: got %0d required %0d", frame_count, exp_frames); end
    endtask

    task automatic test_partial();
        got_d.delete(); got_l.delete();
        m_axis_tready = 1'b1;
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        send_byte(8'hCC, 1'b1);
        wait_words(TRL ? 2 : 1);
        exp_frames++;
        checks++; if (got_d.size() !== (TRL ? 2 : 1)) begin errors++; $display("FAIL partial_count: got %0d required %0d", got_d.size(), TRL ? 2 : 1); end
        if (got_d.size() >= 1) begin
            checks++; if (got_d[0] !== 64'h0000000000CCBBAA) begin errors++; $display("FAIL partial_data: got %h required 0000000000ccbbaa", got_d[0]); end
            checks++; if (got_l[0] !== !TRL) begin errors++; $display("FAIL partial_last: got %b required %b", got_l[0], !TRL); end
        end
        if (TRL && got_d.size() >= 2) begin
            checks++; if (got_d[1] !== 64'd3 || got_l[1] !== 1'b1) begin errors++; $display("FAIL partial_trailer: got %h/%b required 3/1", got_d[1], got_l[1]); end
        end
        checks++; if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL partial_frames: got %0d required %0d", frame_count, exp_frames); end
    endtask

    task automatic test_backpressure();
        got_d.delete(); got_l.delete();
        m_axis_tready = 1'b0;
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_axis);
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 64'h0807060504030201) begin
                errors++; $display("FAIL bp_hold: cycle %0d got %b/%h required 1/0807060504030201", c, m_axis_tvalid, m_axis_tdata); end
            checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL bp_tready: cycle %0d got %b required 0", c, s_axis_tready); end
        end
        @(posedge clk_axis); #1;
        m_axis_tready = 1'b1;
        send_byte(8'h09, 1'b0);
        send_byte(8'h0A, 1'b1);
        wait_words(TRL ? 3 : 2);
        exp_frames++;
        checks++; if (got_d.size() !== (TRL ? 3 : 2)) begin errors++; $display("FAIL bp_count: got %0d required %0d", got_d.size(), TRL ? 3 : 2); end
        if (got_d.size() >= 2) begin
            checks++; if (got_d[0] !== 64'h0807060504030201 || got_l[0] !== 1'b0) begin errors++; $display("FAIL bp_word0: got %h/%b required 0807060504030201/0", got_d[0], got_l[0]); end
            checks++; if (got_d[1] !== 64'h0000000000000A09 || got_l[1] !== !TRL) begin errors++; $display("FAIL bp_word1: got %h/%b required 0a09/%b", got_d[1], got_l[1], !TRL); end
        end
        if (TRL && got_d.size() >= 3) begin
            checks++; if (got_d[2] !== 64'd10 || got_l[2] !== 1'b1) begin errors++; $display("FAIL bp_trailer: got %h/%b required a/1", got_d[2], got_l[2]); end
        end
    endtask

    task automatic test_reset_midframe();
        got_d.delete(); got_l.delete();
        m_axis_tready = 1'b1;
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        rst_axis = 1'b1;
        @(posedge clk_axis); #1;
        rst_axis = 1'b0;
        exp_frames = 0;
        wait_words(1);
        checks++; if (got_d.size() !== 0) begin errors++; $display("FAIL midrst_no_word: got %0d words required 0", got_d.size()); end
        checks++; if (frame_count !== 32'd0) begin errors++; $display("FAIL midrst_frames: got %0d required 0", frame_count); end
        for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i), i == 7);
        wait_words(TRL ? 2 : 1);
        exp_frames++;
        checks++; if (got_d.size() < 1 || got_d[0] !== 64'h1817161514131211 || got_l[0] !== !TRL) begin
            errors++; $display("FAIL midrst_word: got %0d words, first %h required 1817161514131211", got_d.size(), got_d.size() ? got_d[0] : 64'h0); end
        if (TRL) begin
            checks++; if (got_d.size() < 2 || got_d[1] !== 64'd8) begin errors++; $display("FAIL midrst_trailer: got %0d words required trailer 8", got_d.size()); end
        end
    endtask

    task automatic test_back_to_back();
        got_d.delete(); got_l.delete(); exp_d.delete(); exp_l.delete();
        frm.delete(); frm_last.delete();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin frm.push_back(8'h20 + 8'(i)); frm_last.push_back(i == 15); end
        for (int i = 0; i < 3; i++) begin frm.push_back(8'hE0 + 8'(i)); frm_last.push_back(i == 2); end
        for (int i = 0; i < 9; i++) begin frm.push_back(8'h50 + 8'(i)); frm_last.push_back(i == 8); end
        model_frames();
        send_frames();
        wait_words(exp_d.size());
        exp_frames += 3;
        checks++; if (got_d.size() !== exp_d.size()) begin errors++; $display("FAIL b2b_count: got %0d required %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++; if (got_d[i] !== exp_d[i] || got_l[i] !== exp_l[i]) begin
                errors++; $display("FAIL b2b_word%0d: got %h/%b required %h/%b", i, got_d[i], got_l[i], exp_d[i], exp_l[i]); end
        end
        checks++; if (frame_count !== 32'(exp_frames)) begin errors++; $display("FAIL b2b_frames: got %0d required %0d", frame_count, exp_frames); end
    endtask

    task automatic test_long_frame();
        got_d.delete(); got_l.delete();
        m_axis_tready = 1'b1;
        for (int i = 0; i < 70000; i++) send_byte(8'(i), i == 69999);
        wait_words(8751);
        checks++; if (got_d.size() !== 8751) begin errors++; $display("FAIL long_count: got %0d required 8751", got_d.size()); end
        if (got_d.size() >= 8751) begin
            checks++; if (got_d[8749] !== 64'h6F6E6D6C6B6A6968 || got_l[8749] !== 1'b0) begin errors++; $display("FAIL long_last_data: got %h/%b required 6f6e6d6c6b6a6968/0", got_d[8749], got_l[8749]); end
            checks++; if (got_d[8750] !== 64'h000000000000FFFF || got_l[8750] !== 1'b1) begin errors++; $display("FAIL long_trailer: got %h/%b required ffff/1", got_d[8750], got_l[8750]); end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_partial();
        test_backpressure();
        test_reset_midframe();
        test_back_to_back();
        if (TRL) test_long_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
